serial_word_rx: RTL and testbench

Serial-to-parallel word receiver, the receive end of the team's shift-register serial link. It accepts one bit per qualified cycle from a shift-register transmitter, in either shift direction, and assembles WIDTH-bit words. Each completed word is presented on a one-deep valid/ready output buffer, and an overrun is flagged when that buffer cannot accept a new word. It sits between the serial link and the parallel consumer logic.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/word_out_buf.sv | 51 +++++
 rtl/serial_word_rx.sv | 105 ++++++++++
 tb/tb_serial_word_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for both ends of the shift-register serial link.
//   shift_mode_e  : what a shift register does on a given edge
//                   (hold, parallel load, shift right, shift left).
//   BIT_ORDER_*   : bit order on the wire, used as the LSB_FIRST parameter
//                   value of the transmitter and the receiver.
// ---------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } shift_mode_e;

  localparam int BIT_ORDER_MSB = 0;
  localparam int BIT_ORDER_LSB = 1;

endpackage

// File: rtl/word_out_buf.sv
// ---------------------------------------------------------------------------
// word_out_buf
// One-deep valid/ready holding register for assembled words.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   load         : a completed word is offered this edge
//   word         : the completed word
//   dout_ready   : consumer accepts dout this edge
//   dout         : buffered word (holds its value after being consumed)
//   dout_valid   : dout holds an unconsumed word
//   drop         : the offered word cannot be accepted (buffer full, not
//                  being drained); the caller uses this to flag an overrun
// ---------------------------------------------------------------------------
module word_out_buf
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             drop
);

  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;

  // A full buffer that is being drained on this edge can take the new word
  // directly, so back-to-back words never lose a slot.
  assign drop = load && r_dout_valid && !dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (load && (!r_dout_valid || dout_ready)) begin
      r_dout       <= word;
      r_dout_valid <= 1'b1;
    end else if (r_dout_valid && dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: rtl/serial_word_rx.sv
// ---------------------------------------------------------------------------
// serial_word_rx
// Receive end of the shift-register serial link: collects one bit per
// sin_valid edge into a WIDTH-bit word and hands completed words to a
// one-deep valid/ready output buffer.
// Parameters:
//   WIDTH      : word width, 2..32
//   LSB_FIRST  : BIT_ORDER_MSB (shift left, sin enters bit 0) or
//                BIT_ORDER_LSB (shift right, sin enters bit WIDTH-1)
// Ports:
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   sin, sin_valid : serial bit and its qualifier
//   sync           : word boundary; drops any partial word
//   dout, dout_valid, dout_ready : assembled word handshake
//   overrun        : sticky, a completed word was dropped
//   clr_ovr        : clears overrun (a simultaneous new overrun wins)
// ---------------------------------------------------------------------------
module serial_word_rx
  import shift_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = BIT_ORDER_MSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int                CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_base;
  shift_mode_e      w_mode;
  logic             w_complete;
  logic             w_drop;
  logic             r_overrun;

  // sync rewinds the bit count before this edge's capture, so a bit arriving
  // together with sync is the first bit of a fresh word. The shift register
  // itself needs no clearing: a full word always overwrites every bit.
  always_comb begin
    w_cnt_base = sync ? '0 : r_cnt;

    w_mode = MODE_HOLD;
    if (sin_valid) begin
      if (LSB_FIRST == BIT_ORDER_LSB) w_mode = MODE_SHR;
      else                            w_mode = MODE_SHL;
    end

    case (w_mode)
      MODE_SHL: w_sr_next = {r_sr[WIDTH-2:0], sin};
      MODE_SHR: w_sr_next = {sin, r_sr[WIDTH-1:1]};
      default:  w_sr_next = r_sr;
    endcase

    w_complete = sin_valid && (w_cnt_base == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr <= w_sr_next;
      if (sin_valid) r_cnt <= w_complete ? '0 : w_cnt_base + CW'(1);
      else           r_cnt <= w_cnt_base;
    end
  end

  // The buffer sees the shifted value including the current bit, so the
  // word is loaded on the same edge that samples its last bit.
  word_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (w_complete),
    .word      (w_sr_next),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .drop      (w_drop)
  );

  // Setting takes priority over clearing so an overrun on the clearing edge
  // is never lost.
  always_ff @(posedge clk) begin
    if (rst)          r_overrun <= 1'b0;
    else if (w_drop)  r_overrun <= 1'b1;
    else if (clr_ovr) r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;

endmodule

// File: tb/tb_serial_word_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_word_rx
// Drives an MSB-first and an LSB-first receiver (WIDTH=4) from one shared
// input stream. A word-level model (a queue of received bits plus a one-slot
// buffer) predicts every output each cycle; directed scenarios also carry
// literal expected words.
// ---------------------------------------------------------------------------
module tb_serial_word_rx;
  import shift_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sinBit;
  logic         sinValid;
  logic         syncIn;
  logic         doutReady;
  logic         clrOvr;

  logic [W-1:0] doutMsb, doutLsb;
  logic         validMsb, validLsb;
  logic         ovrMsb, ovrLsb;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(W), .LSB_FIRST(BIT_ORDER_MSB)) dutMsb (
    .clk(clk), .rst(rst), .sin(sinBit), .sin_valid(sinValid), .sync(syncIn),
    .dout(doutMsb), .dout_valid(validMsb), .dout_ready(doutReady),
    .overrun(ovrMsb), .clr_ovr(clrOvr)
  );

  serial_word_rx #(.WIDTH(W), .LSB_FIRST(BIT_ORDER_LSB)) dutLsb (
    .clk(clk), .rst(rst), .sin(sinBit), .sin_valid(sinValid), .sync(syncIn),
    .dout(doutLsb), .dout_valid(validLsb), .dout_ready(doutReady),
    .overrun(ovrLsb), .clr_ovr(clrOvr)
  );

  // Behavioural model: index 0 = MSB-first, index 1 = LSB-first.
  bit           mBits[$];
  logic [W-1:0] mDout[2];
  logic         mValid;
  logic         mOvr;
  bit           mInit = 1'b0;

  // The model reacts to the inputs in force at each rising edge.
  always @(posedge clk) begin
    logic [W-1:0] wMsb, wLsb;
    bit           done, dropped;
    if (rst) begin
      mBits.delete();
      mDout[0] = '0;
      mDout[1] = '0;
      mValid   = 1'b0;
      mOvr     = 1'b0;
      mInit    = 1'b1;
    end else begin
      done    = 1'b0;
      dropped = 1'b0;
      wMsb    = '0;
      wLsb    = '0;
      if (syncIn) mBits.delete();
      if (sinValid) begin
        mBits.push_back(sinBit);
        if (mBits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wMsb[W-1-i] = mBits[i];
            wLsb[i]     = mBits[i];
          end
          done = 1'b1;
          mBits.delete();
        end
      end
      if (done) begin
        if (!mValid || doutReady) begin
          mDout[0] = wMsb;
          mDout[1] = wLsb;
          mValid   = 1'b1;
        end else begin
          dropped = 1'b1;
        end
      end else if (mValid && doutReady) begin
        mValid = 1'b0;
      end
      if (dropped)     mOvr = 1'b1;
      else if (clrOvr) mOvr = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model, half a cycle after the edge.
  always @(negedge clk) begin
    if (mInit) begin
      checkOutput("msb.dout",       32'(doutMsb),  32'(mDout[0]));
      checkOutput("lsb.dout",       32'(doutLsb),  32'(mDout[1]));
      checkOutput("msb.dout_valid", 32'(validMsb), 32'(mValid));
      checkOutput("lsb.dout_valid", 32'(validLsb), 32'(mValid));
      checkOutput("msb.overrun",    32'(ovrMsb),   32'(mOvr));
      checkOutput("lsb.overrun",    32'(ovrLsb),   32'(mOvr));
    end
  end

  // Presents one set of inputs for exactly one rising edge, then returns
  // just after that edge so the outputs reflect it.
  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic sy, input logic rd, input logic cl);
    rst       = r;
    sinBit    = s;
    sinValid  = v;
    syncIn    = sy;
    doutReady = rd;
    clrOvr    = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b, input logic rd);
    applyStimulus(1'b0, b, 1'b1, 1'b0, rd, 1'b0);
  endtask

  task automatic idle(input logic rd);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0);
  endtask

  task automatic sendWord(input logic [W-1:0] bits, input logic rd);
    logic [W-1:0] b;
    b = bits;
    for (int i = W - 1; i >= 0; i--) sendBit(b[i], rd);
  endtask

  task automatic checkState(input string tag, input logic [W-1:0] expMsb,
                            input logic [W-1:0] expLsb, input logic expValid,
                            input logic expOvr);
    checkOutput({tag, ".msb"},     32'(doutMsb),  32'(expMsb));
    checkOutput({tag, ".lsb"},     32'(doutLsb),  32'(expLsb));
    checkOutput({tag, ".valid"},   32'(validMsb), 32'(expValid));
    checkOutput({tag, ".overrun"}, 32'(ovrMsb),   32'(expOvr));
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkState("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Bits 1,0,1,1 with the consumer ready: one-cycle valid pulse.
    sendWord(4'b1011, 1'b1);
    checkState("basic", 4'b1011, 4'b1101, 1'b1, 1'b0);
    idle(1'b1);
    checkState("basic.drain", 4'b1011, 4'b1101, 1'b0, 1'b0);

    // Backpressure: second word is dropped and flags overrun.
    sendWord(4'b1010, 1'b0);
    checkState("bp.first", 4'b1010, 4'b0101, 1'b1, 1'b0);
    sendWord(4'b0110, 1'b0);
    checkState("bp.drop", 4'b1010, 4'b0101, 1'b1, 1'b1);
    idle(1'b1);
    checkState("bp.consume", 4'b1010, 4'b0101, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkState("bp.clear", 4'b1010, 4'b0101, 1'b0, 1'b0);

    // Idle gaps inside a word, then a back-to-back word.
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] g;
      g = 4'b1011;
      sendBit(g[W-1-i], 1'b1);
      if (i != W - 1) begin
        idle(1'b1);
        idle(1'b1);
      end
    end
    checkState("gap", 4'b1011, 4'b1101, 1'b1, 1'b0);
    sendWord(4'b0100, 1'b1);
    checkState("b2b", 4'b0100, 4'b0010, 1'b1, 1'b0);
    idle(1'b1);

    // sync mid-word: the bit arriving with sync starts the new word.
    sendBit(1'b1, 1'b1);
    sendBit(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBit(1'b1, 1'b1);
    sendBit(1'b0, 1'b1);
    sendBit(1'b1, 1'b1);
    checkState("sync", 4'b0101, 4'b1010, 1'b1, 1'b0);
    idle(1'b1);

    // Reset with a buffered word and two pending bits.
    sendWord(4'b1110, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkState("midrst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    sendWord(4'b0011, 1'b1);
    checkState("postrst", 4'b0011, 4'b1100, 1'b1, 1'b0);
    idle(1'b1);

    // Randomised traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    1'($urandom),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 19) == 0));
    end
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
